// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-subtract step per cycle, then a single sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_OPS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2} state_t;

  state_t             state_r, state_n;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] p_r, p_n_s, mul_res_s;
  logic [WIDTH-1:0]   d_r;
  logic               is_div_r, neg_q_r, neg_r_r, dz_r;
  logic               busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               accept_s, is_div_s, sgn_s, a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, q_s, r_s, div_sub_s;
  logic [WIDTH:0]     mul_sum_s, div_shl_s;
  logic               div_ge_s;

  assign accept_s = (state_r == IDLE) && start && !flush;
  assign is_div_s = op[1];
  assign sgn_s    = SIGNED_OPS && op[0];
  assign a_neg_s  = sgn_s && a[WIDTH-1];
  assign b_neg_s  = sgn_s && b[WIDTH-1];
  assign a_mag_s  = a_neg_s ? (~a + WIDTH'(1)) : a;
  assign b_mag_s  = b_neg_s ? (~b + WIDTH'(1)) : b;
  assign b_zero_s = is_div_s && (b == {WIDTH{1'b0}});

  // Datapath step: multiply keeps {partial, multiplier} in p_r; divide keeps {remainder, dividend/quotient}.
  assign mul_sum_s = {1'b0, p_r[2*WIDTH-1:WIDTH]} + {1'b0, d_r};
  assign div_shl_s = {p_r[2*WIDTH-1:WIDTH], p_r[WIDTH-1]};
  assign div_ge_s  = div_shl_s >= {1'b0, d_r};
  assign div_sub_s = WIDTH'(div_shl_s - {1'b0, d_r});

  // One iteration of shift-add or restoring division
  always_comb begin
    p_n_s = p_r;
    if (is_div_r) begin
      p_n_s = {(div_ge_s ? div_sub_s : div_shl_s[WIDTH-1:0]), p_r[WIDTH-2:0], div_ge_s};
    end else if (p_r[0]) begin
      p_n_s = {mul_sum_s, p_r[WIDTH-1:1]};
    end else begin
      p_n_s = {1'b0, p_r[2*WIDTH-1:1]};
    end
  end

  assign mul_res_s = neg_q_r ? (~p_r + (2*WIDTH)'(1)) : p_r;
  assign q_s       = neg_q_r ? (~p_r[WIDTH-1:0] + WIDTH'(1)) : p_r[WIDTH-1:0];
  assign r_s       = neg_r_r ? (~p_r[2*WIDTH-1:WIDTH] + WIDTH'(1)) : p_r[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = b_zero_s ? FIX : BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (flush) begin
          state_n = IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_n = FIX;
        end else begin
          state_n = BUSY;
        end
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration, result write-back and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      p_r        <= {(2*WIDTH){1'b0}};
      d_r        <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_n != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_hi) hi_r <= wdata;
          if (wr_lo) lo_r <= wdata;
          if (accept_s) begin
            cnt_r    <= CW'(WIDTH - 1);
            is_div_r <= is_div_s;
            dz_r     <= b_zero_s;
            // Divide by zero skips iteration; FIX passes p_r straight through
            if (b_zero_s) begin
              p_r     <= {a, {WIDTH{1'b1}}};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else if (is_div_s) begin
              p_r     <= {{WIDTH{1'b0}}, a_mag_s};
              d_r     <= b_mag_s;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
            end else begin
              p_r     <= {{WIDTH{1'b0}}, b_mag_s};
              d_r     <= a_mag_s;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            p_r <= p_n_s;
            if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            if (is_div_r) begin
              hi_r <= r_s;
              lo_r <= q_s;
            end else begin
              {hi_r, lo_r} <= mul_res_s;
            end
            div_zero_r <= dz_r;
            done_r     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor pops on done.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.WIDTH(W), .SIGNED_OPS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit integer arithmetic on the architectural operands
  function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    logic [63:0] p;
    e.dz = 1'b0;
    if (o[1] && y == '0) begin
      e.lo = '1;
      e.hi = x;
      e.dz = 1'b1;
      return e;
    end
    if (o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    if (!o[1]) begin
      p    = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no outstanding op");
      end else begin
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  // Called at a negedge; launches op there and returns at the negedge where done is seen.
  // At cycle poke_k after launch, start/wr_lo are pulsed while busy and must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke_k);
    int lat, k, bcnt;
    lat   = (o[1] && y == '0) ? 2 : W + 2;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb_q.push_back(ref_model(o, x, y));
    k    = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      k++;
      start = (k == poke_k);
      wr_lo = (k == poke_k);
      wdata = $urandom;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom);
      if (busy) bcnt++;
    end while (!done && k < 100);
    start = 1'b0;
    wr_lo = 1'b0;
    check("latency", 64'(k), 64'(lat));
    check("busy_cycles", 64'(bcnt), 64'(lat - 1));
  endtask

  initial begin
    logic [W-1:0] sv_hi, sv_lo, ra, rb;
    logic         sv_dz;
    int           sel, k;
    rst = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_done", 64'(done), 64'd0);
    wr_hi = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'hCAFE_0001);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    run_op(2'd1, 32'hFFFF_FFF9, 32'd3, 0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd7, 12);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);
    run_op(2'd2, 32'd5, 32'd0, 0);
    check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("dz_hi", 64'(hi), 64'd5);
    check("dz_flag", 64'(div_zero), 64'd1);

    // mthi in the same cycle as start: write lands first, result overwrites later
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'h5A5A_0F0F;
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    sb_q.push_back(ref_model(2'd0, 32'd6, 32'd7));
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    check("mthi_with_start", 64'(hi), 64'h5A5A_0F0F);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mthi_start_latency", 64'(k), 64'(W + 2));

    // flush in cycle 10 of a mult
    @(negedge clk);
    sv_hi = hi; sv_lo = lo; sv_dz = div_zero;
    start = 1'b1; op = 2'd1; a = 32'h1234_5678; b = 32'h8765_4321;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo", {hi, lo}, {sv_hi, sv_lo});
    check("flush_dz", 64'(div_zero), 64'(sv_dz));

    // start together with flush in IDLE
    start = 1'b1; flush = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);

    // reset in cycle 5 of a divu
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'($urandom_range(0, 3)) - 32'd1;
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
